// File: rtl/multi_pulse_detect_pkg.sv
// rtl/multi_pulse_detect_pkg.sv - shared types and helpers for multi_pulse_detect
//
// Package pulse_detect_pkg:
//   mode_e      : per-channel edge select (OFF / RISE / FALL / BOTH)
//   state_e     : per-channel stretch FSM state (IDLE / STRETCH)
//   edge_match(): mode qualification of raw rise/fall flags
package pulse_detect_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } state_e;

    function automatic logic edge_match(input mode_e m, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        unique case (m)
            OFF:  hit = 1'b0;
            RISE: hit = rise;
            FALL: hit = fall;
            BOTH: hit = rise | fall;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_pulse_detect_if.sv
// rtl/multi_pulse_detect_if.sv - signal bundle between stimulus side and multi_pulse_detect
//
// Parameters: CH_NUM channels, CNT_W stretch length width.
// Signals:
//   sig_in      [CH_NUM]   asynchronous level inputs
//   mode        [2*CH_NUM] per-channel edge select, 2 bits per channel
//   stretch_len [CNT_W]    pulse length minus one
//   level_out   [CH_NUM]   synchronized levels
//   pulse_out   [CH_NUM]   stretched detection pulses
//   retrig      [CH_NUM]   one-cycle retrigger flags
//   evt_clr / evt_sticky   only with MULTI_PULSE_DETECT_STICKY_EN
// Modports: master drives inputs of the detector, slave is the detector.
interface multi_pulse_detect_if #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 8
);
    logic [CH_NUM-1:0]   sig_in;
    logic [2*CH_NUM-1:0] mode;
    logic [CNT_W-1:0]    stretch_len;
    logic [CH_NUM-1:0]   level_out;
    logic [CH_NUM-1:0]   pulse_out;
    logic [CH_NUM-1:0]   retrig;
`ifdef MULTI_PULSE_DETECT_STICKY_EN
    logic [CH_NUM-1:0]   evt_clr;
    logic [CH_NUM-1:0]   evt_sticky;
`endif

    modport master (
        output sig_in, mode, stretch_len,
        input  level_out, pulse_out, retrig
`ifdef MULTI_PULSE_DETECT_STICKY_EN
        , output evt_clr
        , input  evt_sticky
`endif
    );

    modport slave (
        input  sig_in, mode, stretch_len,
        output level_out, pulse_out, retrig
`ifdef MULTI_PULSE_DETECT_STICKY_EN
        , input  evt_clr
        , output evt_sticky
`endif
    );

endinterface

// File: rtl/multi_pulse_detect_pd_channel.sv
// rtl/multi_pulse_detect_pd_channel.sv - one detector channel: sync chain, edge detect, stretch FSM
//
// Module pd_channel. Optional feature macro: MULTI_PULSE_DETECT_STICKY_EN.
// Ports:
//   clk_i, rst_i     block clock, synchronous active-high reset
//   sig_i            asynchronous level input
//   mode_i           edge select, sampled every cycle
//   len_i            stretch length minus one, sampled on load/reload only
//   level_o          last synchronizer stage
//   pulse_o          stretched pulse (high while FSM is in STRETCH)
//   retrig_o         one-cycle flag for an edge arriving during STRETCH
//   evt_clr_i        sticky clear (sticky build only)
//   evt_sticky_o     sticky event flag (sticky build only)
module pd_channel
    import pulse_detect_pkg::*;
#(
    parameter int   SYNC_STAGE = 2,
    parameter int   CNT_W      = 8,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  mode_e            mode_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             level_o,
    output logic             pulse_o,
    output logic             retrig_o
`ifdef MULTI_PULSE_DETECT_STICKY_EN
    ,
    input  logic             evt_clr_i,
    output logic             evt_sticky_o
`endif
);

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  prev_q;
    logic                  rise_q;
    logic                  fall_q;
    logic                  level;
    logic                  qual_edge;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  retrig_q, retrig_d;

    assign level = sync_q[SYNC_STAGE-1];

    // Synchronizer and previous-level copy share the reset level so that a
    // release with sig_i at that level produces no spurious edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGE{RST_BIT}};
            prev_q <= RST_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], sig_i};
            prev_q <= level;
            // Raw edges are registered; mode is applied a cycle later so the
            // current mode decides whether the edge counts.
            rise_q <= level & ~prev_q;
            fall_q <= ~level & prev_q;
        end
    end

    assign qual_edge = edge_match(mode_i, rise_q, fall_q);

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            retrig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retrig_q <= retrig_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retrig_d = 1'b0;
        if (mode_i == OFF) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (qual_edge) begin
                        state_d = STRETCH;
                        cnt_d   = len_i;
                    end
                end
                STRETCH: begin
                    if (qual_edge) begin
                        cnt_d    = len_i;
                        retrig_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        level_o  = level;
        pulse_o  = (state_q == STRETCH);
        retrig_o = retrig_q;
    end

`ifdef MULTI_PULSE_DETECT_STICKY_EN
    logic sticky_q;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (qual_edge) begin
            sticky_q <= 1'b1;
        end else if (evt_clr_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign evt_sticky_o = sticky_q;
`endif

endmodule

// File: rtl/multi_pulse_detect.sv
// rtl/multi_pulse_detect.sv - multi-channel synchronizing edge detector with pulse stretch
//
// Optional feature macro: MULTI_PULSE_DETECT_STICKY_EN (adds evt_clr / evt_sticky).
// Ports:
//   sync_clk   block clock
//   sync_rst   synchronous active-high reset
//   bus        multi_pulse_detect_if.slave: sig_in, mode, stretch_len in;
//              level_out, pulse_out, retrig out (plus sticky pair when enabled)
// Parameters: CH_NUM (1..32), SYNC_STAGE (2..4), CNT_W, RST_LEVEL per channel.
module multi_pulse_detect
    import pulse_detect_pkg::*;
#(
    parameter int                CH_NUM     = 4,
    parameter int                SYNC_STAGE = 2,
    parameter int                CNT_W      = 8,
    parameter logic [CH_NUM-1:0] RST_LEVEL  = {CH_NUM{1'b0}}
) (
    input  logic                  sync_clk,
    input  logic                  sync_rst,
    multi_pulse_detect_if.slave   bus
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pd_channel #(
            .SYNC_STAGE (SYNC_STAGE),
            .CNT_W      (CNT_W),
            .RST_BIT    (RST_LEVEL[i])
        ) u_ch (
            .clk_i        (sync_clk),
            .rst_i        (sync_rst),
            .sig_i        (bus.sig_in[i]),
            .mode_i       (mode_e'(bus.mode[2*i +: 2])),
            .len_i        (bus.stretch_len),
            .level_o      (bus.level_out[i]),
            .pulse_o      (bus.pulse_out[i]),
            .retrig_o     (bus.retrig[i])
`ifdef MULTI_PULSE_DETECT_STICKY_EN
            ,
            .evt_clr_i    (bus.evt_clr[i]),
            .evt_sticky_o (bus.evt_sticky[i])
`endif
        );
    end

endmodule
